// File: rtl/run_control_pkg.sv
// Shared types and helpers for the run/step controller: state encodings,
// divider frequency codes and the state-to-divider-input mapping.
package run_control_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    PHALT = 2'd3
  } state_t;

  localparam logic [1:0] FREQ_SLOW = 2'b00;
  localparam logic [1:0] FREQ_MED  = 2'b01;
  localparam logic [1:0] FREQ_FAST = 2'b10;
  localparam logic [1:0] FREQ_MAX  = 2'b11;

  function automatic logic halt_for(input state_t s);
    return (s == IDLE) || (s == PHALT);
  endfunction

  // Edge-counted stepping cannot keep up with the fastest divider setting.
  function automatic logic [1:0] freq_for(input state_t s, input logic [1:0] sw);
    if (s == STEP && sw == FREQ_MAX) return FREQ_MED;
    return sw;
  endfunction

endpackage

// File: rtl/run_control_debouncer.sv
// Button conditioner: 2-FF synchronizer followed by a stability counter that
// emits a single press pulse per accepted high level.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      // The counter only runs while the synced level disagrees with the
      // accepted one, so any bounce back restarts the stability window.
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/run_control.sv
// Run/step controller: turns debounced run/step presses into divider Halt and
// freq controls, counts processor clock edges and runs multi-cycle steps.
module run_control
  import run_control_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic [1:0]  sw_freq,
  input  logic [7:0]  step_len,
  input  logic        proc_halt,
  input  logic        clk_out,
  output logic        Halt,
  output logic [1:0]  freq,
  output logic [31:0] cycle_count,
  output logic [1:0]  ctl_state,
  output logic        step_done
);

  logic   run_pulse;
  logic   step_pulse;
  logic   co_sync1;
  logic   co_sync2;
  logic   co_prev;
  logic   co_rise;
  logic   rise_reg;
  logic [7:0] remaining;
  state_t state;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_run),
    .press (run_pulse)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_step),
    .press (step_pulse)
  );

  assign co_rise   = co_sync2 & ~co_prev;
  assign ctl_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      co_sync1 <= 1'b0;
      co_sync2 <= 1'b0;
      co_prev  <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      co_sync1 <= clk_out;
      co_sync2 <= co_sync1;
      co_prev  <= co_sync2;
      rise_reg <= co_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (co_rise) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  // Step bookkeeping uses the registered edge, so Halt rises four clk cycles
  // after the final stepped edge while clk_out is still high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= 8'd0;
      Halt      <= 1'b1;
      freq      <= FREQ_SLOW;
      step_done <= 1'b0;
    end else begin
      step_done <= 1'b0;
      Halt      <= halt_for(state);
      freq      <= freq_for(state, sw_freq);
      if (state != PHALT && proc_halt) begin
        state <= PHALT;
        Halt  <= halt_for(PHALT);
        freq  <= freq_for(PHALT, sw_freq);
      end else begin
        case (state)
          IDLE: begin
            if (run_pulse) begin
              state <= RUN;
              Halt  <= halt_for(RUN);
              freq  <= freq_for(RUN, sw_freq);
            end else if (step_pulse) begin
              state     <= STEP;
              remaining <= (step_len == 8'd0) ? 8'd1 : step_len;
              Halt      <= halt_for(STEP);
              freq      <= freq_for(STEP, sw_freq);
            end
          end
          RUN: begin
            if (run_pulse) begin
              state <= IDLE;
              Halt  <= halt_for(IDLE);
              freq  <= freq_for(IDLE, sw_freq);
            end
          end
          STEP: begin
            if (rise_reg) begin
              if (remaining <= 8'd1) begin
                remaining <= 8'd0;
                state     <= IDLE;
                step_done <= 1'b1;
                Halt      <= halt_for(IDLE);
                freq      <= freq_for(IDLE, sw_freq);
              end else begin
                remaining <= remaining - 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/run_control.md
# run_control

Run/step controller for the MIPS processor's divided clock. It turns the board's run and step buttons into the `Halt` and `freq` inputs of the clock divider, and observes the divider's `clk_out` to count processor cycles. It also supports multi-cycle single-stepping. It sits between the board I/O and the clock divider, in the fast `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable `clk` cycles required to accept a button level (10 ms at 25 MHz); benches use a small value.
- `clk`, in, 1: board clock; same clock that drives the divider.
- `reset`, in, 1: synchronous, active-high.
- `btn_run`, in, 1: raw run/stop button, asynchronous, active-high.
- `btn_step`, in, 1: raw step button, asynchronous, active-high.
- `sw_freq`, in, 2: requested divider frequency code.
- `step_len`, in, 8: processor cycles per step press; 0 is treated as 1.
- `proc_halt`, in, 1: processor executed a halt instruction.
- `clk_out`, in, 1: divided processor clock from the divider.
- `Halt`, out, 1: to divider; 1 freezes `clk_out` high.
- `freq`, out, 2: to divider frequency select.
- `cycle_count`, out, 32: rising edges of `clk_out` since reset.
- `ctl_state`, out, 2: current state (IDLE=0, RUN=1, STEP=2, PHALT=3).
- `step_done`, out, 1: one-cycle pulse when a step burst completes.

## Operation
- **Button inputs**
  - Each button passes through a 2-FF synchronizer and then a debouncer.
  - The debouncer emits a one-cycle press pulse once the synced level has been high for `DEBOUNCE_CYCLES` consecutive cycles.
  - It re-arms only after the level has been low for `DEBOUNCE_CYCLES` consecutive cycles.
- **Processor clock edges**
  - `clk_out` is 2-FF synchronized.
  - A rising edge is detected when the synced value is 1 and its previous value was 0.
  - Each rising edge increments `cycle_count`, which wraps modulo 2^32.
- **State machine**
  - IDLE, on run pulse: go to RUN.
  - IDLE, on step pulse: load `remaining` = max(`step_len`, 1) and go to STEP.
  - RUN, on run pulse: go to IDLE. Step pulses are ignored in RUN.
  - STEP, on each detected rising edge: decrement `remaining`. When it reaches 0, pulse `step_done` and go to IDLE. Run and step pulses are ignored in STEP.
  - Any state except PHALT, with `proc_halt`=1: go to PHALT. This has priority over button pulses.
  - PHALT is left only by `reset`.
  - If run and step pulses arrive in the same cycle in IDLE, run wins.
- **Outputs by state**
  - `Halt` = 0 in RUN and STEP; 1 in IDLE and PHALT.
  - `freq` = `sw_freq`, except in STEP with `sw_freq`=2'b11, where `freq`=2'b01. The fastest divider setting is too fast for edge-counted stepping.
- **Reset mid-operation**: all state, counters and debouncers clear in the cycle `reset` is sampled high, regardless of the current state.

## Timing
- Reset values:
  - `Halt`=1, `freq`=2'b00, `cycle_count`=0, `ctl_state`=IDLE, `step_done`=0.
  - Internally: `remaining`=0, synchronizers=0, debouncers disarmed-low.
- Button latency: synced level stable for `DEBOUNCE_CYCLES` gives a press pulse 2 + `DEBOUNCE_CYCLES` cycles after the raw edge. State changes on the following edge.
- `clk_out` edge latency:
  - A rising edge on `clk_out` is counted 3 `clk` cycles later.
  - `Halt` rises on the same edge that enters IDLE, i.e. 4 cycles after the last stepped `clk_out` rise.
  - Since `clk_out` is then high, the divider freezes it with no extra processor edge.
- All outputs are registered.
- `step_done` is high for exactly one cycle, coincident with the first IDLE cycle.

## Structure
- Shared package `run_control_pkg` holds:
  - state encodings IDLE/RUN/STEP/PHALT;
  - frequency codes `FREQ_SLOW`=2'b00, `FREQ_MED`=2'b01, `FREQ_FAST`=2'b10, `FREQ_MAX`=2'b11.
- Sub-module `debouncer`, parameterized by `DEBOUNCE_CYCLES`, contains the synchronizer, stability counter and pulse output. It is instantiated twice.
- The `clk_out` synchronizer, edge detector, FSM and counters stay in the top level.

## Test plan
- **Reset and run**: with `DEBOUNCE_CYCLES`=4, deassert reset and hold `btn_run` high for 8 cycles -> `ctl_state` goes to RUN and `Halt`=0; after 10 emulated `clk_out` rises, `cycle_count`=10.
- **Step burst**: `step_len`=3, step press, 5 `clk_out` rises -> `remaining` reaches 0 on the 3rd rise; `step_done` pulses once, `Halt`=1, `cycle_count`=3, and later rises stop once the divider freezes.
- **Fast-mode step**: `step_len`=0, `sw_freq`=2'b11, step press -> `freq`=2'b01 during STEP, one cycle counted, then `freq`=2'b11 again in IDLE.
- **Processor halt priority**: `proc_halt` and a run pulse in the same IDLE cycle -> PHALT, `Halt`=1; further run/step presses leave it in PHALT; `reset` returns it to IDLE with `cycle_count`=0.
- **Bounce rejection and coincidence**:
  - A `btn_step` glitch high for 3 cycles -> no pulse.
  - Run and step pulses in the same cycle from IDLE -> RUN.
- **Reset mid-STEP**: assert `reset` after 1 of 3 step cycles -> all outputs at reset values on the next cycle.
